// File: rtl/fft_2_sched.sv
// Address/handshake sequencer for an in-place radix-2 DIF FFT sharing one butterfly.
// Reads issue in natural order per stage; writes follow after a fixed LAT-cycle delay line.
module fft_2_sched #(
   parameter int unsigned LOG2N = 4,
   parameter int unsigned LAT   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [LOG2N-1:0] LastStage = LOG2N'(LOG2N - 1);
   localparam logic [LOG2N-2:0] LastBfly  = '1;
   localparam logic [3:0]       LastDrain = 4'(LAT - 1);

   state_e           r_state;
   logic [LOG2N-1:0] r_stage;
   logic [LOG2N-2:0] r_b;
   logic [3:0]       r_drain;
   logic             r_done;

   logic             w_rd_en;
   logic [LOG2N-1:0] w_shamt;
   logic [LOG2N-1:0] w_span;
   logic [LOG2N-1:0] w_mask;
   logic [LOG2N-1:0] w_bx;
   logic [LOG2N-1:0] w_pos;
   logic [LOG2N-1:0] w_addr_a;
   logic [LOG2N-1:0] w_addr_b;
   logic [LOG2N-2:0] w_tw;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_stage <= '0;
         r_b     <= '0;
         r_drain <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_state <= StRun;
                  r_stage <= '0;
                  r_b     <= '0;
               end
            end
            StRun: begin
               if (!hold) begin
                  // Counter wraps to zero after the last butterfly of the stage
                  r_b <= r_b + 1'b1;
                  if (r_b == LastBfly) begin
                     r_state <= StDrain;
                     r_drain <= '0;
                  end
               end
            end
            StDrain: begin
               r_drain <= r_drain + 4'd1;
               if (r_drain == LastDrain) begin
                  r_drain <= '0;
                  if (r_stage == LastStage) begin
                     r_state <= StIdle;
                     r_stage <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= StRun;
                     r_stage <= r_stage + 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // span = N >> (stage+1); the group bits of b shift up one place to skip the lower leg
   always_comb begin
      w_rd_en  = (r_state == StRun) && !hold;
      w_shamt  = LastStage - r_stage;
      w_span   = LOG2N'(1) << w_shamt;
      w_mask   = w_span - LOG2N'(1);
      w_bx     = {1'b0, r_b};
      w_pos    = w_bx & w_mask;
      w_addr_a = ((w_bx & ~w_mask) << 1) | w_pos;
      w_addr_b = w_addr_a | w_span;
      w_tw     = w_pos[LOG2N-2:0] << r_stage;
   end

   assign busy      = (r_state != StIdle);
   assign done      = r_done;
   assign stage     = r_stage;
   assign rd_en     = w_rd_en;
   assign rd_addr_a = w_rd_en ? w_addr_a : '0;
   assign rd_addr_b = w_rd_en ? w_addr_b : '0;
   assign tw_addr   = w_rd_en ? w_tw : '0;

   logic             r_pv [LAT];
   logic [LOG2N-1:0] r_pa [LAT];
   logic [LOG2N-1:0] r_pb [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            r_pv[i] <= 1'b0;
            r_pa[i] <= '0;
            r_pb[i] <= '0;
         end
      end else begin
         r_pv[0] <= w_rd_en;
         r_pa[0] <= rd_addr_a;
         r_pb[0] <= rd_addr_b;
         for (int unsigned i = 1; i < LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
            r_pb[i] <= r_pb[i-1];
         end
      end
   end

   assign wr_en     = r_pv[LAT-1];
   assign wr_addr_a = r_pv[LAT-1] ? r_pa[LAT-1] : '0;
   assign wr_addr_b = r_pv[LAT-1] ? r_pb[LAT-1] : '0;

endmodule

// File: tb/tb_fft_2_sched.sv
// Bench for fft_2_sched: a 16-point/LAT=3 instance against a cycle-level model built from
// the stage/butterfly rules, plus a fixed-table check of a 4-point/LAT=1 instance.
module tb_fft_2_sched;
   localparam int L  = 4;
   localparam int LT = 3;
   localparam int N  = 16;
   localparam int H  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, hold;
   logic         busy, done, rd_en, wr_en;
   logic [L-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [L-2:0] tw_addr;

   logic       rst2, start2, hold2;
   logic       busy2, done2, rd_en2, wr_en2;
   logic [1:0] stage2, rd_a2, rd_b2, wr_a2, wr_b2;
   logic [0:0] tw2;

   fft_2_sched #(.LOG2N(L), .LAT(LT)) u_dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
      .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   fft_2_sched #(.LOG2N(2), .LAT(1)) u_dut2 (
      .clk(clk), .rst(rst2), .start(start2), .hold(hold2), .busy(busy2), .done(done2),
      .stage(stage2), .rd_en(rd_en2), .rd_addr_a(rd_a2), .rd_addr_b(rd_b2),
      .tw_addr(tw2), .wr_en(wr_en2), .wr_addr_a(wr_a2), .wr_addr_b(wr_b2)
   );

   int n_pass = 0;
   int n_total = 0;

   // Model state: run flag, stage, butterfly index, drain cycles left, done pulse
   bit         m_busy, m_done;
   int         m_stage, m_b, m_drain;
   logic [8:0] m_q[$];
   logic [8:0] e_rd;
   logic [30:0] e_vec, o_vec;

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_stage = 0; m_b = 0; m_drain = 0;
      m_q = {};
      for (int i = 0; i < LT; i++) m_q.push_back(9'd0);
   endtask

   // Apply inputs for this cycle, then at the falling edge form expected and observed vectors
   task automatic drive(input bit st, input bit hd, input bit rs);
      bit en;
      int span, grp, pos, a, b, tw;
      start = st; hold = hd; rst = rs;
      @(negedge clk);
      en   = m_busy && (m_drain == 0) && !hold;
      span = N >> (m_stage + 1);
      grp  = m_b / span;
      pos  = m_b % span;
      a    = en ? grp * 2 * span + pos : 0;
      b    = en ? a + span : 0;
      tw   = en ? pos << m_stage : 0;
      e_rd  = {en, 4'(a), 4'(b)};
      e_vec = {m_busy, m_done, 4'(m_stage), en, 4'(a), 4'(b), 3'(tw), m_q[0]};
      o_vec = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b};
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         m_q.push_back(e_rd);
         void'(m_q.pop_front());
         m_done = 0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_stage = 0; m_b = 0; m_drain = 0;
            end
         end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) begin
               if (m_stage == L - 1) begin
                  m_busy = 0; m_done = 1; m_stage = 0; m_b = 0;
               end else begin
                  m_stage++; m_b = 0;
               end
            end
         end else if (!hold) begin
            m_b++;
            if (m_b == H) m_drain = LT;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 1);
      tick();
      drive(1, 0, 1);
      n_total++;
      if (o_vec !== 31'd0) $display("FAIL reset_outputs got=%h exp=0", o_vec);
      else n_pass++;
      tick();
      drive(0, 0, 0);
      n_total++;
      if (o_vec !== 31'd0) $display("FAIL reset_beats_start got=%h exp=0", o_vec);
      else n_pass++;
      tick();
   endtask

   task automatic test_nominal();
      bit exp_rd;
      for (int c = 0; c < 50; c++) begin
         drive(c == 0, 0, 0);
         n_total++;
         if (o_vec !== e_vec) $display("FAIL nominal_model cyc=%0d got=%h exp=%h", c, o_vec, e_vec);
         else n_pass++;
         exp_rd = (c >= 1) && (c <= 44) && (((c - 1) % 11) < 8);
         n_total++;
         if (rd_en !== exp_rd || done !== (c == 45) || busy !== (c >= 1 && c <= 44))
            $display("FAIL nominal_sched cyc=%0d got=%b%b%b exp=%b%b%b", c, rd_en, done, busy,
                     exp_rd, c == 45, c >= 1 && c <= 44);
         else n_pass++;
         if (c == 4 || c == 17 || c == 30 || c == 41) begin
            logic [10:0] want;
            case (c)
               4:       want = {4'd3, 4'd11, 3'd3};
               17:      want = {4'd9, 4'd13, 3'd2};
               30:      want = {4'd13, 4'd15, 3'd4};
               default: want = {4'd14, 4'd15, 3'd0};
            endcase
            n_total++;
            if ({rd_addr_a, rd_addr_b, tw_addr} !== want)
               $display("FAIL nominal_addr cyc=%0d got=%h exp=%h", c,
                        {rd_addr_a, rd_addr_b, tw_addr}, want);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 52; c++) begin
         drive(c == 0, (c >= 3 && c <= 5), 0);
         n_total++;
         if (o_vec !== e_vec) $display("FAIL hold_model cyc=%0d got=%h exp=%h", c, o_vec, e_vec);
         else n_pass++;
         n_total++;
         if (done !== (c == 48)) $display("FAIL hold_done cyc=%0d got=%b exp=%b", c, done, c == 48);
         else n_pass++;
         if (c == 6) begin
            n_total++;
            if ({rd_en, rd_addr_a, rd_addr_b} !== {1'b1, 4'd2, 4'd10})
               $display("FAIL hold_resume got=%h exp=%h", {rd_en, rd_addr_a, rd_addr_b},
                        {1'b1, 4'd2, 4'd10});
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_start_busy();
      for (int c = 0; c < 55; c++) begin
         drive(c == 0 || c == 20 || c == 46, 0, 0);
         n_total++;
         if (o_vec !== e_vec) $display("FAIL restart_model cyc=%0d got=%h exp=%h", c, o_vec, e_vec);
         else n_pass++;
         n_total++;
         if (done !== (c == 45)) $display("FAIL restart_done cyc=%0d got=%b exp=%b", c, done, c == 45);
         else n_pass++;
         if (c == 47) begin
            n_total++;
            if ({rd_en, rd_addr_a, rd_addr_b, stage} !== {1'b1, 4'd0, 4'd8, 4'd0})
               $display("FAIL restart_first got=%h exp=%h", {rd_en, rd_addr_a, rd_addr_b, stage},
                        {1'b1, 4'd0, 4'd8, 4'd0});
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 1);
      tick();
      for (int c = 0; c < 40; c++) begin
         drive(c == 0 || c == 30, 0, c == 25);
         n_total++;
         if (o_vec !== e_vec) $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", c, o_vec, e_vec);
         else n_pass++;
         if (c == 25) begin
            n_total++;
            if (stage !== 4'd2) $display("FAIL rstmid_stage got=%0d exp=2", stage);
            else n_pass++;
         end
         if (c >= 26 && c <= 29) begin
            n_total++;
            if (o_vec !== 31'd0) $display("FAIL rstmid_quiet cyc=%0d got=%h exp=0", c, o_vec);
            else n_pass++;
         end
         if (c == 31) begin
            n_total++;
            if ({rd_en, rd_addr_a, rd_addr_b, stage} !== {1'b1, 4'd0, 4'd8, 4'd0})
               $display("FAIL rstmid_restart got=%h exp=%h", {rd_en, rd_addr_a, rd_addr_b, stage},
                        {1'b1, 4'd0, 4'd8, 4'd0});
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_random();
      drive(0, 0, 1);
      tick();
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 249) == 0);
         n_total++;
         if (o_vec !== e_vec) $display("FAIL random_model cyc=%0d got=%h exp=%h", c, o_vec, e_vec);
         else n_pass++;
         tick();
      end
      drive(0, 0, 1);
      tick();
   endtask

   // Reads of the 4-point transform: {en, a, b, tw}
   function automatic logic [5:0] small_rd(input int c);
      case (c)
         1:       return {1'b1, 2'd0, 2'd2, 1'b0};
         2:       return {1'b1, 2'd1, 2'd3, 1'b1};
         4:       return {1'b1, 2'd0, 2'd1, 1'b0};
         5:       return {1'b1, 2'd2, 2'd3, 1'b0};
         default: return 6'd0;
      endcase
   endfunction

   task automatic test_small();
      logic [5:0] r_now, r_prev;
      logic [14:0] got, want;
      hold2 = 1'b0;
      rst2 = 1'b1;
      drive(0, 0, 0);
      tick();
      rst2 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         start2 = (c == 0);
         drive(0, 0, 0);
         r_now  = small_rd(c);
         r_prev = small_rd(c - 1);
         want = {c >= 1 && c <= 6, c == 7, 2'(c >= 4 && c <= 6), r_now, r_prev[5:1]};
         got  = {busy2, done2, stage2, rd_en2, rd_a2, rd_b2, tw2, wr_en2, wr_a2, wr_b2};
         n_total++;
         if (got !== want) $display("FAIL small_n4 cyc=%0d got=%h exp=%h", c, got, want);
         else n_pass++;
         tick();
      end
      start2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      rst2 = 1'b1; start2 = 1'b0; hold2 = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_nominal();
      test_hold();
      test_start_busy();
      test_reset_mid();
      test_random();
      test_small();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
